// File: rtl/screen_sequencer_pkg.sv
// Shared screen encodings and default frame counts for the Pong game-flow sequencer.
// The screen encoding is also consumed by the colour output mux.
package screen_pkg;

    typedef enum logic [1:0] {
        TITLE_SCREEN = 2'd0,
        GAME         = 2'd1,
        CREDITS      = 2'd2,
        GAME_OVER    = 2'd3
    } screen_e;

    localparam int DEF_SCORE_W       = 4;
    localparam int DEF_WIN_SCORE     = 7;
    localparam int DEF_BLANK_FRAMES  = 8;
    localparam int DEF_OVER_FRAMES   = 180;
    localparam int DEF_CREDIT_FRAMES = 300;
    localparam int DEF_FCNT_W        = 9;

    // Unsigned "has this player won" compare; scores past the target still count as a win.
    function automatic logic score_reached(input logic [DEF_SCORE_W-1:0] score,
                                           input logic [DEF_SCORE_W-1:0] target);
        return (score >= target);
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Handshake bundle between input conditioning / score counters and the screen sequencer.
interface screen_sequencer_if
    import screen_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               FrameTick;
    logic               StartBtn;
    logic [SCORE_W-1:0] LeftScore;
    logic [SCORE_W-1:0] RightScore;
    screen_e            Select;
    logic               Blank;
    logic               GameRun;
    logic               ScoreClear;
    logic               Winner;

    modport master (
        output FrameTick, StartBtn, LeftScore, RightScore,
        input  Select, Blank, GameRun, ScoreClear, Winner
    );

    modport slave (
        input  FrameTick, StartBtn, LeftScore, RightScore,
        output Select, Blank, GameRun, ScoreClear, Winner
    );
endinterface

// File: rtl/screen_sequencer_frame_timer.sv
// Shared frame counter: counts enabled frame ticks and flags the tick that reaches the target.
module frame_timer #(
    parameter int FCNT_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              tick_i,
    input  logic              en_i,
    input  logic [FCNT_W-1:0] target_i,
    output logic              done_o
);
    logic [FCNT_W-1:0] cnt_q;
    logic [FCNT_W-1:0] cnt_d;
    logic              cnt_en_s;
    logic              hit_s;

    // done_o is deliberately combinational so the owner can act on the same edge that samples the tick.
    always_comb begin
        cnt_en_s = tick_i & en_i;
        hit_s    = (cnt_q == (target_i - FCNT_W'(1)));
        done_o   = cnt_en_s & hit_s;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_en_s) begin
            if (hit_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + FCNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/screen_sequencer.sv
// Pong game-flow FSM: title -> game -> game-over -> credits -> title, with blanking on
// every screen change and a run gate for the paddle/ball logic.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int WIN_SCORE     = DEF_WIN_SCORE,
    parameter int BLANK_FRAMES  = DEF_BLANK_FRAMES,
    parameter int OVER_FRAMES   = DEF_OVER_FRAMES,
    parameter int CREDIT_FRAMES = DEF_CREDIT_FRAMES,
    parameter int FCNT_W        = DEF_FCNT_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    screen_sequencer_if.slave bus
);
    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
    localparam logic [FCNT_W-1:0]  BLANK_T  = FCNT_W'(BLANK_FRAMES);
    localparam logic [FCNT_W-1:0]  OVER_T   = FCNT_W'(OVER_FRAMES);
    localparam logic [FCNT_W-1:0]  CREDIT_T = FCNT_W'(CREDIT_FRAMES);

    screen_e sel_q, sel_d;
    logic    blank_q, blank_d;
    logic    run_q, run_d;
    logic    clr_q, clr_d;
    logic    win_q, win_d;
    logic    prev_q;

    logic              start_s;
    logic              left_won_s;
    logic              right_won_s;
    logic              trans_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;
    logic [FCNT_W-1:0] tmr_target_s;
    logic              tmr_done_s;

    frame_timer #(.FCNT_W(FCNT_W)) u_timer (
        .clk_i    (Clock),
        .rst_ni   (Reset_n),
        .clear_i  (tmr_clear_s),
        .tick_i   (bus.FrameTick),
        .en_i     (tmr_en_s),
        .target_i (tmr_target_s),
        .done_o   (tmr_done_s)
    );

    // Next-state, blanking and timer control; start edges during blanking are simply dropped.
    always_comb begin
        sel_d        = sel_q;
        blank_d      = blank_q;
        win_d        = win_q;
        clr_d        = 1'b0;
        trans_s      = 1'b0;
        start_s      = bus.StartBtn & ~prev_q;
        left_won_s   = (bus.LeftScore >= WIN_S);
        right_won_s  = (bus.RightScore >= WIN_S);
        tmr_en_s     = blank_q | (sel_q == GAME_OVER) | (sel_q == CREDITS);
        tmr_target_s = blank_q ? BLANK_T : ((sel_q == CREDITS) ? CREDIT_T : OVER_T);
        if (blank_q) begin
            if (tmr_done_s) begin
                blank_d = 1'b0;
            end else begin
                blank_d = 1'b1;
            end
        end else begin
            case (sel_q)
                TITLE_SCREEN: begin
                    if (start_s) begin
                        sel_d   = GAME;
                        clr_d   = 1'b1;
                        trans_s = 1'b1;
                    end else begin
                        sel_d = TITLE_SCREEN;
                    end
                end
                GAME: begin
                    if (run_q && (left_won_s || right_won_s)) begin
                        sel_d   = GAME_OVER;
                        win_d   = right_won_s & ~left_won_s;
                        trans_s = 1'b1;
                    end else begin
                        sel_d = GAME;
                    end
                end
                GAME_OVER: begin
                    if (start_s) begin
                        sel_d   = GAME;
                        clr_d   = 1'b1;
                        trans_s = 1'b1;
                    end else if (tmr_done_s) begin
                        sel_d   = CREDITS;
                        trans_s = 1'b1;
                    end else begin
                        sel_d = GAME_OVER;
                    end
                end
                CREDITS: begin
                    if (start_s || tmr_done_s) begin
                        sel_d   = TITLE_SCREEN;
                        trans_s = 1'b1;
                    end else begin
                        sel_d = CREDITS;
                    end
                end
                default: begin
                    sel_d   = TITLE_SCREEN;
                    trans_s = 1'b1;
                end
            endcase
        end
        if (trans_s) begin
            blank_d = 1'b1;
        end else begin
            blank_d = blank_d;
        end
        tmr_clear_s = trans_s | (blank_q & tmr_done_s);
        run_d       = (sel_d == GAME) & ~blank_d;
    end

    // State and registered outputs; the start history resets high so a held button cannot fire.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_q   <= TITLE_SCREEN;
            blank_q <= 1'b0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            win_q   <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            sel_q   <= sel_d;
            blank_q <= blank_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            win_q   <= win_d;
            prev_q  <= bus.StartBtn;
        end
    end

    assign bus.Select     = sel_q;
    assign bus.Blank      = blank_q;
    assign bus.GameRun    = run_q;
    assign bus.ScoreClear = clr_q;
    assign bus.Winner     = win_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with short frame counts.
module tb_screen_sequencer;
    import screen_pkg::*;

    logic Clock;
    logic Reset_n;
    int   checks;
    int   failures;
    logic sc_seen;

    screen_sequencer_if #(.SCORE_W(4)) bus ();

    screen_sequencer #(
        .SCORE_W       (4),
        .WIN_SCORE     (3),
        .BLANK_FRAMES  (2),
        .OVER_FRAMES   (3),
        .CREDIT_FRAMES (4),
        .FCNT_W        (9)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One FrameTick pulse sampled on the next edge, followed by one idle cycle.
    task automatic tick();
        bus.FrameTick = 1'b1;
        cyc(1);
        bus.FrameTick = 1'b0;
        cyc(1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sc_seen = 1'b0;
        Reset_n = 1'b0;
        bus.FrameTick = 1'b0;
        bus.StartBtn = 1'b1;
        bus.LeftScore = 4'd0;
        bus.RightScore = 4'd0;
        #22;
        chk("rst_select", 32'(bus.Select), 32'd0);
        chk("rst_blank", 32'(bus.Blank), 32'd0);
        chk("rst_gamerun", 32'(bus.GameRun), 32'd0);
        chk("rst_scoreclear", 32'(bus.ScoreClear), 32'd0);
        chk("rst_winner", 32'(bus.Winner), 32'd0);
        Reset_n = 1'b1;
        cyc(1);

        // Button held high through reset must not start a game.
        for (int i = 0; i < 10; i++) begin
            bus.FrameTick = 1'b1;
            cyc(1);
            sc_seen = sc_seen | bus.ScoreClear;
            bus.FrameTick = 1'b0;
            cyc(1);
            sc_seen = sc_seen | bus.ScoreClear;
        end
        chk("held_select", 32'(bus.Select), 32'd0);
        chk("held_noclear", 32'(sc_seen), 32'd0);

        bus.StartBtn = 1'b0;
        cyc(1);
        bus.StartBtn = 1'b1;
        cyc(1);
        chk("start_select", 32'(bus.Select), 32'd1);
        chk("start_clear", 32'(bus.ScoreClear), 32'd1);
        chk("start_blank", 32'(bus.Blank), 32'd1);
        chk("start_run", 32'(bus.GameRun), 32'd0);
        bus.StartBtn = 1'b0;
        cyc(1);
        chk("clear_one_cycle", 32'(bus.ScoreClear), 32'd0);
        tick();
        chk("blank_after_1", 32'(bus.Blank), 32'd1);
        bus.FrameTick = 1'b1;
        cyc(1);
        bus.FrameTick = 1'b0;
        chk("blank_after_2", 32'(bus.Blank), 32'd0);
        chk("run_after_blank", 32'(bus.GameRun), 32'd1);
        cyc(1);

        // Right reaches WIN_SCORE alone.
        bus.LeftScore = 4'd2;
        bus.RightScore = 4'd3;
        cyc(1);
        chk("over_select", 32'(bus.Select), 32'd3);
        chk("over_winner_r", 32'(bus.Winner), 32'd1);
        chk("over_run", 32'(bus.GameRun), 32'd0);
        chk("over_blank", 32'(bus.Blank), 32'd1);
        bus.LeftScore = 4'd0;
        bus.RightScore = 4'd0;

        // Start edge during blanking is swallowed.
        bus.StartBtn = 1'b1;
        cyc(1);
        bus.StartBtn = 1'b0;
        cyc(1);
        chk("blank_start_ignored", 32'(bus.Select), 32'd3);
        tick();
        tick();
        chk("over_unblank", 32'(bus.Blank), 32'd0);
        bus.StartBtn = 1'b1;
        cyc(1);
        bus.StartBtn = 1'b0;
        chk("rematch_select", 32'(bus.Select), 32'd1);
        chk("rematch_clear", 32'(bus.ScoreClear), 32'd1);
        chk("rematch_winner_hold", 32'(bus.Winner), 32'd1);

        // Stale winning scores during blanking must wait for the blank to drop.
        bus.LeftScore = 4'd3;
        bus.RightScore = 4'd3;
        cyc(3);
        chk("stale_no_trans", 32'(bus.Select), 32'd1);
        tick();
        tick();
        chk("stale_trans", 32'(bus.Select), 32'd3);
        chk("tie_winner_left", 32'(bus.Winner), 32'd0);
        bus.LeftScore = 4'd0;
        bus.RightScore = 4'd0;

        // Auto-advance: 2 blank ticks, 3 dwell ticks to credits, 2 + 4 more to title.
        tick();
        tick();
        tick();
        tick();
        chk("over_dwell_2", 32'(bus.Select), 32'd3);
        bus.FrameTick = 1'b1;
        cyc(1);
        bus.FrameTick = 1'b0;
        chk("credits_select", 32'(bus.Select), 32'd2);
        chk("credits_blank", 32'(bus.Blank), 32'd1);
        cyc(1);
        for (int i = 0; i < 5; i++) tick();
        chk("credits_dwell_3", 32'(bus.Select), 32'd2);
        bus.FrameTick = 1'b1;
        cyc(1);
        bus.FrameTick = 1'b0;
        chk("title_select", 32'(bus.Select), 32'd0);
        chk("title_noclear", 32'(bus.ScoreClear), 32'd0);
        cyc(1);

        // New game, left wins, then start coincides with the third dwell tick.
        tick();
        tick();
        bus.StartBtn = 1'b1;
        cyc(1);
        bus.StartBtn = 1'b0;
        chk("game2_select", 32'(bus.Select), 32'd1);
        tick();
        tick();
        bus.LeftScore = 4'd5;
        cyc(1);
        chk("over2_select", 32'(bus.Select), 32'd3);
        chk("over2_winner_l", 32'(bus.Winner), 32'd0);
        bus.LeftScore = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        bus.StartBtn = 1'b1;
        bus.FrameTick = 1'b1;
        cyc(1);
        bus.StartBtn = 1'b0;
        bus.FrameTick = 1'b0;
        chk("prio_select", 32'(bus.Select), 32'd1);
        chk("prio_clear", 32'(bus.ScoreClear), 32'd1);

        // Reach credits, then reset asynchronously between edges.
        tick();
        tick();
        bus.RightScore = 4'd3;
        cyc(1);
        chk("over3_winner_r", 32'(bus.Winner), 32'd1);
        bus.RightScore = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        chk("credits2_select", 32'(bus.Select), 32'd2);
        tick();
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_select", 32'(bus.Select), 32'd0);
        chk("async_blank", 32'(bus.Blank), 32'd0);
        chk("async_winner", 32'(bus.Winner), 32'd0);
        #10;
        Reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
